// File: rtl/stack_lifo_bcd.sv
// stack_lifo_bcd: parametrised LIFO stack with occupancy count, replace-top,
// sticky overflow/underflow flags, and a sequential double-dabble converter that
// presents the registered top-of-stack as BCD digits.
// Latency: Dout/count/empty/full update 1 edge after the request.
//   BCD becomes valid WIDTH+1 edges after the edge that changed Dout.
// Backpressure: none. Refused operations are no-ops that raise a sticky flag.
// Ports:
//   clk, rst          - clock, synchronous active-high reset
//   push, pop, Din    - stack requests and write data
//   clr_err           - clears overflow/underflow; a same-cycle error event wins
//   Dout, count       - registered top-of-stack (0 when empty) and occupancy
//   empty, full       - decoded from the registered count
//   overflow/underflow- sticky error flags
//   BCD, bcd_valid    - converted top-of-stack; digit 0 in bits [3:0]
module stack_lifo_bcd #(
  parameter int WIDTH  = 8,
  parameter int DEPTH  = 8,
  parameter int DIGITS = 3,
  localparam int CW    = $clog2(DEPTH+1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic                  pop,
  input  logic [WIDTH-1:0]      Din,
  input  logic                  clr_err,
  output logic [WIDTH-1:0]      Dout,
  output logic [CW-1:0]         count,
  output logic                  empty,
  output logic                  full,
  output logic                  overflow,
  output logic                  underflow,
  output logic [4*DIGITS-1:0]   BCD,
  output logic                  bcd_valid
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int IW = $clog2(WIDTH+1);
  localparam int BW = 4*DIGITS;
  localparam int SW = BW + WIDTH;

  // ---------------- stack ----------------
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             ovf_q, ovf_d, unf_q, unf_d;
  logic             wr_en;
  logic [AW-1:0]    wr_idx;
  logic [CW-1:0]    cnt_m1, cnt_m2;
  logic             ovf_ev, unf_ev;

  assign empty = (count_q == '0);
  assign full  = (count_q == CW'(DEPTH));

  always_comb begin
    count_d = count_q;
    dout_d  = dout_q;
    wr_en   = 1'b0;
    wr_idx  = '0;
    ovf_ev  = 1'b0;
    unf_ev  = 1'b0;
    cnt_m1  = count_q - CW'(1);
    cnt_m2  = count_q - CW'(2);
    if (push && pop && !empty) begin
      // replace-top: legal even when full
      wr_en  = 1'b1;
      wr_idx = cnt_m1[AW-1:0];
      dout_d = Din;
    end else if (push) begin
      // also covers push+pop on an empty stack
      if (full) begin
        ovf_ev = 1'b1;
      end else begin
        wr_en   = 1'b1;
        wr_idx  = count_q[AW-1:0];
        count_d = count_q + CW'(1);
        dout_d  = Din;
      end
    end else if (pop) begin
      if (empty) begin
        unf_ev = 1'b1;
      end else begin
        count_d = cnt_m1;
        dout_d  = (count_q == CW'(1)) ? '0 : mem_q[cnt_m2[AW-1:0]];
      end
    end
    // a new error event takes priority over clr_err
    ovf_d = ovf_ev | (ovf_q & ~clr_err);
    unf_d = unf_ev | (unf_q & ~clr_err);
  end

  // storage has no reset; only entries below count are ever read
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_idx] <= Din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
      dout_q  <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      dout_q  <= dout_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  // ---------------- double-dabble converter ----------------
  // shift register layout: {bcd digits, binary}; binary shifts into digit 0
  logic [WIDTH-1:0] src_q, src_d;
  logic [SW-1:0]    sh_q, sh_d, sh_adj, sh_step;
  logic [IW-1:0]    iter_q, iter_d;
  logic [BW-1:0]    bcd_q, bcd_d;
  logic             vld_q, vld_d;

  always_comb begin
    sh_adj = sh_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (sh_q[WIDTH+4*i +: 4] >= 4'd5)
        sh_adj[WIDTH+4*i +: 4] = sh_q[WIDTH+4*i +: 4] + 4'd3;
    end
    sh_step = {sh_adj[SW-2:0], 1'b0};
  end

  always_comb begin
    src_d  = src_q;
    sh_d   = sh_q;
    iter_d = iter_q;
    bcd_d  = bcd_q;
    vld_d  = vld_q;
    if (dout_q != src_q) begin
      // new top value (also restarts an in-flight conversion)
      src_d  = dout_q;
      sh_d   = {{BW{1'b0}}, dout_q};
      iter_d = IW'(WIDTH);
      vld_d  = 1'b0;
    end else if (iter_q != '0) begin
      sh_d   = sh_step;
      iter_d = iter_q - IW'(1);
      if (iter_q == IW'(1)) begin
        bcd_d = sh_step[SW-1:WIDTH];
        vld_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      src_q  <= '0;
      sh_q   <= '0;
      iter_q <= '0;
      bcd_q  <= '0;
      vld_q  <= 1'b1;
    end else begin
      src_q  <= src_d;
      sh_q   <= sh_d;
      iter_q <= iter_d;
      bcd_q  <= bcd_d;
      vld_q  <= vld_d;
    end
  end

  assign Dout      = dout_q;
  assign count     = count_q;
  assign overflow  = ovf_q;
  assign underflow = unf_q;
  assign BCD       = bcd_q;
  assign bcd_valid = vld_q;

endmodule

// File: tb/tb_stack_lifo_bcd.sv
module tb_stack_lifo_bcd;
  localparam int WIDTH  = 8;
  localparam int DEPTH  = 8;
  localparam int DIGITS = 3;
  localparam int CW     = $clog2(DEPTH+1);

  logic clk = 1'b0;
  logic rst = 1'b0, push = 1'b0, pop = 1'b0, clr_err = 1'b0;
  logic [WIDTH-1:0]    Din = '0;
  logic [WIDTH-1:0]    Dout;
  logic [CW-1:0]       count;
  logic                empty, full, overflow, underflow, bcd_valid;
  logic [4*DIGITS-1:0] BCD;

  stack_lifo_bcd #(.WIDTH(WIDTH), .DEPTH(DEPTH), .DIGITS(DIGITS)) dut (
    .clk(clk), .rst(rst), .push(push), .pop(pop), .Din(Din), .clr_err(clr_err),
    .Dout(Dout), .count(count), .empty(empty), .full(full),
    .overflow(overflow), .underflow(underflow), .BCD(BCD), .bcd_valid(bcd_valid)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // reference model: stack as a queue, conversion as "value + countdown"
  logic [WIDTH-1:0]    q[$];
  logic                ovf_m = 1'b0, unf_m = 1'b0, vld_m = 1'b1;
  logic [WIDTH-1:0]    src_m = '0;
  logic [4*DIGITS-1:0] bcd_m = '0;
  int                  tmr = 0;

  function automatic logic [WIDTH-1:0] top_m();
    return (q.size() > 0) ? q[q.size()-1] : '0;
  endfunction

  function automatic logic [4*DIGITS-1:0] to_bcd(input logic [WIDTH-1:0] v);
    logic [4*DIGITS-1:0] r;
    int x;
    r = '0;
    x = int'(v);
    for (int i = 0; i < DIGITS; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("count",     64'(count),     64'(q.size()));
    chk("dout",      64'(Dout),      64'(top_m()));
    chk("empty",     64'(empty),     64'(q.size() == 0));
    chk("full",      64'(full),      64'(q.size() == DEPTH));
    chk("overflow",  64'(overflow),  64'(ovf_m));
    chk("underflow", 64'(underflow), 64'(unf_m));
    chk("bcd_valid", 64'(bcd_valid), 64'(vld_m));
    chk("bcd",       64'(BCD),       64'(bcd_m));
  endtask

  task automatic model_edge(input logic r, input logic pu, input logic po,
                            input logic [WIDTH-1:0] d, input logic c);
    logic [WIDTH-1:0] old;
    logic ovf_e, unf_e;
    if (r) begin
      q.delete();
      ovf_m = 1'b0; unf_m = 1'b0;
      src_m = '0; tmr = 0; bcd_m = '0; vld_m = 1'b1;
    end else begin
      old = top_m();
      if (old != src_m) begin
        src_m = old; tmr = WIDTH; vld_m = 1'b0;
      end else if (tmr > 0) begin
        tmr--;
        if (tmr == 0) begin
          bcd_m = to_bcd(src_m);
          vld_m = 1'b1;
        end
      end
      ovf_e = 1'b0; unf_e = 1'b0;
      if (pu && po && q.size() > 0) q[q.size()-1] = d;
      else if (pu) begin
        if (q.size() == DEPTH) ovf_e = 1'b1; else q.push_back(d);
      end else if (po) begin
        if (q.size() == 0) unf_e = 1'b1; else void'(q.pop_back());
      end
      ovf_m = ovf_e | (ovf_m & ~c);
      unf_m = unf_e | (unf_m & ~c);
    end
  endtask

  task automatic step(input logic r, input logic pu, input logic po,
                      input logic [WIDTH-1:0] d, input logic c);
    rst = r; push = pu; pop = po; Din = d; clr_err = c;
    @(posedge clk);
    model_edge(r, pu, po, d, c);
    #1;
    check_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, '0, 1'b0);
  endtask

  task automatic psh(input logic [WIDTH-1:0] d);
    step(1'b0, 1'b1, 1'b0, d, 1'b0);
  endtask

  task automatic pp();
    step(1'b0, 1'b0, 1'b1, '0, 1'b0);
  endtask

  initial begin
    // reset
    step(1'b1, 1'b0, 1'b0, '0, 1'b0);
    step(1'b1, 1'b0, 1'b0, '0, 1'b0);
    chk("rst_bcd_valid", 64'(bcd_valid), 64'd1);
    chk("rst_empty", 64'(empty), 64'd1);

    // push 5,17,200 then wait for conversion
    psh(8'd5); psh(8'd17); psh(8'd200);
    chk("tp1_count", 64'(count), 64'd3);
    chk("tp1_dout", 64'(Dout), 64'd200);
    idle(9);
    chk("tp1_valid", 64'(bcd_valid), 64'd1);
    chk("tp1_bcd", 64'(BCD), 64'h200);

    // fill, overflow, clear, drain
    step(1'b1, 1'b0, 1'b0, '0, 1'b0);
    for (int i = 1; i <= 8; i++) psh(WIDTH'(i));
    psh(8'd99);
    chk("tp2_full", 64'(full), 64'd1);
    chk("tp2_count", 64'(count), 64'd8);
    chk("tp2_dout", 64'(Dout), 64'd8);
    chk("tp2_ovf", 64'(overflow), 64'd1);
    step(1'b0, 1'b0, 1'b0, '0, 1'b1);
    chk("tp2_ovf_clr", 64'(overflow), 64'd0);
    for (int i = 1; i <= 8; i++) begin
      pp();
      chk("tp2_pop_dout", 64'(Dout), 64'(8 - i));
    end
    chk("tp2_empty", 64'(empty), 64'd1);

    // underflow, and error event beats clr_err
    pp();
    chk("tp3_unf", 64'(underflow), 64'd1);
    step(1'b0, 1'b0, 1'b1, '0, 1'b1);
    chk("tp3_unf_hold", 64'(underflow), 64'd1);
    step(1'b0, 1'b0, 1'b0, '0, 1'b1);
    idle(10);

    // replace-top
    step(1'b1, 1'b0, 1'b0, '0, 1'b0);
    psh(8'd10); psh(8'd20);
    step(1'b0, 1'b1, 1'b1, 8'd255, 1'b0);
    chk("tp4_count", 64'(count), 64'd2);
    chk("tp4_dout", 64'(Dout), 64'd255);
    idle(9);
    chk("tp4_bcd", 64'(BCD), 64'h255);
    pp();
    chk("tp4_pop", 64'(Dout), 64'd10);
    idle(10);

    // restart mid-conversion; identical rewrite does not restart
    psh(8'd123);
    idle(2);
    psh(8'd45);
    for (int i = 0; i < 8; i++) begin
      idle(1);
      chk("tp5_busy", 64'(bcd_valid), 64'd0);
    end
    idle(1);
    chk("tp5_valid", 64'(bcd_valid), 64'd1);
    chk("tp5_bcd", 64'(BCD), 64'h045);
    step(1'b0, 1'b1, 1'b1, 8'd45, 1'b0);
    idle(1);
    chk("tp5_same", 64'(bcd_valid), 64'd1);

    // reset mid-conversion, then push+pop on empty
    psh(8'd77);
    idle(3);
    step(1'b1, 1'b0, 1'b0, '0, 1'b0);
    chk("tp6_count", 64'(count), 64'd0);
    chk("tp6_bcd", 64'(BCD), 64'd0);
    chk("tp6_valid", 64'(bcd_valid), 64'd1);
    step(1'b0, 1'b1, 1'b1, 8'd9, 1'b0);
    chk("tp6_pp_count", 64'(count), 64'd1);
    chk("tp6_pp_dout", 64'(Dout), 64'd9);
    chk("tp6_pp_unf", 64'(underflow), 64'd0);

    // randomized traffic against the model
    for (int k = 0; k < 600; k++) begin
      logic r, pu, po, c;
      logic [WIDTH-1:0] d;
      r  = ($urandom_range(0, 79) == 0);
      pu = ($urandom_range(0, 9) < 5);
      po = ($urandom_range(0, 9) < 4);
      c  = ($urandom_range(0, 7) == 0);
      d  = WIDTH'($urandom);
      step(r, pu, po, d, c);
      if ($urandom_range(0, 19) == 0) idle(WIDTH + 2);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/stack_lifo_bcd.md
Name: stack_lifo_bcd

Overview:
Parametrised LIFO stack that generalises the fixed 8x8 stack. Width and depth are set by parameters. It adds an occupancy count, simultaneous push+pop (replace-top), and sticky overflow/underflow error flags. It also includes an integrated sequential double-dabble converter that presents the top-of-stack value as BCD digits with a valid flag. It sits between user input logic and the 7-segment display path.

Parameters:
WIDTH, 8, data word width in bits (>=2)
DEPTH, 8, number of stack entries (>=2)
DIGITS, 3, BCD digits produced; must satisfy 10^DIGITS > 2^WIDTH-1
CW (localparam), $clog2(DEPTH+1), width of count

Ports:
clk  in  1  system clock, all state updates on rising edge
rst  in  1  synchronous active-high reset
push  in  1  push request, sampled each rising edge
pop  in  1  pop request, sampled each rising edge
Din  in  WIDTH  data written on push
clr_err  in  1  clears overflow/underflow flags
Dout  out  WIDTH  registered top-of-stack value; 0 when empty
count  out  CW  number of valid entries, 0..DEPTH
empty  out  1  count==0
full  out  1  count==DEPTH
overflow  out  1  sticky: push refused because the stack was full
underflow  out  1  sticky: pop refused because the stack was empty
BCD  out  4*DIGITS  BCD of last converted top; digit 0 in bits [3:0]
bcd_valid  out  1  BCD corresponds to current Dout

Behaviour:
- Reset (rst=1 at edge): count=0, Dout=0, empty=1, full=0, overflow=0, underflow=0, BCD=0, bcd_valid=1, converter idle. Storage contents are don't-care.
- Operation per edge, where E=empty and F=full before the edge:
  - push & !pop & !F: mem[count]<=Din, count+1, Dout<=Din.
  - push & !pop & F: no state change, overflow<=1.
  - pop & !push & !E: count-1, Dout<=new top (mem[count-2]) or 0 if the stack becomes empty.
  - pop & !push & E: no state change, underflow<=1.
  - push & pop & !E: replace top, mem[count-1]<=Din, count unchanged, Dout<=Din. Legal even when full; no flags.
  - push & pop & E: treated as a plain push, count=1, Dout<=Din; no underflow.
  - Neither asserted: hold.
- Flag priority: clr_err=1 clears both flags in that cycle. A new error event in the same cycle wins and sets its flag to 1.
- Dout, count, empty and full all reflect the operation at the same edge (latency 1 edge, no bypass). empty and full are decoded from registered count.
- Converter (sequential double-dabble):
  - Holds a shadow copy src of the last Dout it started converting.
  - Any edge where Dout != src: src<=Dout, load the shift register, iter<=WIDTH, bcd_valid<=0. BCD output holds its old value.
  - Each following edge with iter>0 performs one iteration: add 3 to every digit >=5, then shift left 1. iter decrements.
  - The edge where iter goes 1->0 writes the result to BCD and sets bcd_valid<=1.
  - Total latency: BCD valid WIDTH+1 edges after the edge that changed Dout.
  - If Dout changes mid-conversion, the conversion restarts with the new value. The partial result is discarded and bcd_valid stays 0.
  - If Dout is rewritten with the same value (e.g. replace-top with an identical Din), no restart occurs.
- Reset mid-conversion: abort; BCD=0, bcd_valid=1.
- Arithmetic: count never wraps; it saturates logically because refused operations are no-ops. The storage index is always < DEPTH.

Test Plan:
- Reset, then push 5,17,200 on consecutive edges -> count=3, Dout=200; 9 edges after the last push bcd_valid=1 and BCD=0x200 (BCD2=2, BCD1=0, BCD0=0).
- Push 8 values 1..8, then push 99 -> full=1, count=8, Dout=8, overflow=1. Pulse clr_err -> overflow=0. Pop 8 times -> Dout sequence 7..1 then 0, empty=1.
- From empty, pop -> underflow=1, count=0, Dout=0. Then assert pop and clr_err in the same cycle while empty -> underflow stays 1.
- Stack [10,20], assert push+pop with Din=255 -> count=2, Dout=255, BCD=0x255 after 9 edges. Pop -> Dout=10.
- Push 123, then 3 edges later push 45 (mid-conversion) -> bcd_valid stays 0 and BCD=0x045 9 edges after the second push; 0x123 never appears.
- Push 77 and assert rst 4 edges later -> count=0, Dout=0, BCD=0, bcd_valid=1 on the next edge. Empty push+pop with Din=9 -> count=1, Dout=9, no flags.
